// File: rtl/onehot_encoder_pkg.sv
// Shared definitions for the one-hot encoder tree: legality helper,
// per-level split calculation and the implementation-style constants.
package onehot_encoder_pkg;

  typedef enum int {
    IMP_FLAT_MASK = 0,
    IMP_FLAT_LOOP = 1,
    IMP_TREE_CAT  = 2,
    IMP_TREE_LOOP = 3,
    IMP_TREE_MASK = 4
  } imp_e;

  // True when n is a positive power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // Number of children for a node of the given width. When the index width
  // is not a multiple of the split width, the node absorbs the remainder
  // with a narrower split so every level below it uses the full radix.
  function automatic int level_split(input int width, input int split);
    int wl;
    int sl;
    int rem;
    wl = $clog2(width);
    sl = $clog2(split);
    if (width <= split || sl == 0) return width;
    rem = wl % sl;
    if (rem != 0) return 1 << rem;
    return split;
  endfunction

endpackage

// File: rtl/onehot_encoder_node.sv
// Combinational one-hot encoder node, self-recursive via generate.
// Optional error detection is enabled with ONEHOT_ENCODER_ERR_EN.
module onehot_encoder_node
  import onehot_encoder_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0]         din,
  output logic                     vld,
  output logic [$clog2(WIDTH)-1:0] idx
`ifdef ONEHOT_ENCODER_ERR_EN
  ,
  output logic                     err
`endif
);

  // Flat styles encode the whole vector at once; tree styles stop recursing
  // once the node is no wider than the radix.
  localparam bit FLAT = (IMPLEMENTATION < IMP_TREE_CAT) || (WIDTH <= SPLIT);

  if (FLAT) begin : g_flat
    localparam int IDX_W = $clog2(WIDTH);

    // Index bit b is the OR of every input whose position has bit b set
    always_comb begin
      vld = |din;
      idx = '0;
      if (IMPLEMENTATION == IMP_FLAT_LOOP || IMPLEMENTATION == IMP_TREE_LOOP) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (din[i]) idx = idx | IDX_W'(i);
        end
      end else begin
        for (int b = 0; b < IDX_W; b++) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (((i >> b) & 1) != 0) idx[b] = idx[b] | din[i];
          end
        end
      end
    end

`ifdef ONEHOT_ENCODER_ERR_EN
    // Flag a second set bit seen while scanning upward
    always_comb begin
      logic seen;
      seen = 1'b0;
      err  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        err  = err | (seen & din[i]);
        seen = seen | din[i];
      end
    end
`endif

  end else begin : g_tree
    localparam int NS  = level_split(WIDTH, SPLIT);
    localparam int CW  = WIDTH / NS;
    localparam int CIW = $clog2(CW);
    localparam int GW  = $clog2(NS);

    logic [NS-1:0]  child_vld;
    logic [CIW-1:0] child_idx [NS];
`ifdef ONEHOT_ENCODER_ERR_EN
    logic [NS-1:0]  child_err;
`endif

    for (genvar gi = 0; gi < NS; gi++) begin : g_child
      onehot_encoder_node #(
        .WIDTH          (CW),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
      ) u_child (
        .din (din[gi*CW +: CW]),
        .vld (child_vld[gi]),
        .idx (child_idx[gi])
`ifdef ONEHOT_ENCODER_ERR_EN
        ,
        .err (child_err[gi])
`endif
      );
    end

    // Group number of valid children goes in the MSBs, child indices OR below
    always_comb begin
      logic [GW-1:0]  grp;
      logic [CIW-1:0] low;
      grp = '0;
      low = '0;
      vld = |child_vld;
      if (IMPLEMENTATION == IMP_TREE_LOOP) begin
        for (int g = 0; g < NS; g++) begin
          if (child_vld[g]) grp = grp | GW'(g);
          low = low | child_idx[g];
        end
      end else if (IMPLEMENTATION == IMP_TREE_MASK) begin
        for (int g = 0; g < NS; g++) begin
          grp = grp | ({GW{child_vld[g]}} & GW'(g));
          low = low | ({CIW{child_vld[g]}} & child_idx[g]);
        end
      end else begin
        for (int b = 0; b < GW; b++) begin
          for (int g = 0; g < NS; g++) begin
            if (((g >> b) & 1) != 0) grp[b] = grp[b] | child_vld[g];
          end
        end
        for (int g = 0; g < NS; g++) low = low | child_idx[g];
      end
      idx = {grp, low};
    end

`ifdef ONEHOT_ENCODER_ERR_EN
    // Error when two or more children are valid or any child already erred
    always_comb begin
      err = (|child_err) || ((child_vld & (child_vld - NS'(1))) != '0);
    end
`endif
  end

endmodule

// File: rtl/onehot_encoder_tree_pipe.sv
// One-hot to binary encoder built from a radix-SPLIT tree, registered output.
// Define ONEHOT_ENCODER_ERR_EN to add the enc_err multi-hot flag output.
module onehot_encoder_tree_pipe
  import onehot_encoder_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         dec_vld,
  output logic [$clog2(WIDTH)-1:0] enc_idx,
  output logic                     enc_vld
`ifdef ONEHOT_ENCODER_ERR_EN
  ,
  output logic                     enc_err
`endif
);

  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);

  if (!is_pow2(WIDTH) || WIDTH < 2) begin : g_bad_width
    $error("onehot_encoder_tree_pipe: WIDTH must be a power of two >= 2");
  end
  if (!is_pow2(SPLIT) || SPLIT_LOG < 1 || SPLIT > WIDTH) begin : g_bad_split
    $error("onehot_encoder_tree_pipe: SPLIT must be a power of two in 2..WIDTH");
  end
  if (IMPLEMENTATION < IMP_FLAT_MASK || IMPLEMENTATION > IMP_TREE_MASK) begin : g_bad_imp
    $error("onehot_encoder_tree_pipe: IMPLEMENTATION must be 0..4");
  end

  logic                 root_vld;
  logic [WIDTH_LOG-1:0] root_idx;
  logic                 enc_vld_d, enc_vld_q;
  logic [WIDTH_LOG-1:0] enc_idx_d, enc_idx_q;
`ifdef ONEHOT_ENCODER_ERR_EN
  logic                 root_err;
  logic                 enc_err_d, enc_err_q;
`endif

  onehot_encoder_node #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_root (
    .din (dec_vld),
    .vld (root_vld),
    .idx (root_idx)
`ifdef ONEHOT_ENCODER_ERR_EN
    ,
    .err (root_err)
`endif
  );

  // Next-state values are simply the combinational encode of this cycle
  always_comb begin
    enc_vld_d = root_vld;
    enc_idx_d = root_idx;
`ifdef ONEHOT_ENCODER_ERR_EN
    enc_err_d = root_err;
`endif
  end

  // Output register; reset discards whatever was in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_vld_q <= 1'b0;
      enc_idx_q <= '0;
`ifdef ONEHOT_ENCODER_ERR_EN
      enc_err_q <= 1'b0;
`endif
    end else begin
      enc_vld_q <= enc_vld_d;
      enc_idx_q <= enc_idx_d;
`ifdef ONEHOT_ENCODER_ERR_EN
      enc_err_q <= enc_err_d;
`endif
    end
  end

  assign enc_vld = enc_vld_q;
  assign enc_idx = enc_idx_q;
`ifdef ONEHOT_ENCODER_ERR_EN
  assign enc_err = enc_err_q;
`endif

endmodule

// File: tb/tb_onehot_encoder_tree_pipe.sv
// Self-checking bench: every IMPLEMENTATION across four WIDTH/SPLIT pairs,
// all driven from one stimulus bus and compared against a reference model.
// Covers enc_err when ONEHOT_ENCODER_ERR_EN is defined.
module tb_onehot_encoder_tree_pipe;

  localparam int NCFG = 4;
  localparam int NIMP = 5;
  localparam int NDUT = NCFG * NIMP;

  function automatic int cfg_w(input int c);
    case (c)
      0:       return 16;
      1:       return 8;
      2:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      0:       return 4;
      1:       return 2;
      2:       return 4;
      default: return 4;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [31:0] obs_idx [NDUT];
  logic        obs_vld [NDUT];
`ifdef ONEHOT_ENCODER_ERR_EN
  logic        obs_err [NDUT];
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int txn          = 0;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    for (genvar gj = 0; gj < NIMP; gj++) begin : g_imp
      localparam int W = cfg_w(gi);
      logic [$clog2(W)-1:0] idx_w;
      logic                 vld_w;
`ifdef ONEHOT_ENCODER_ERR_EN
      logic                 err_w;
`endif
      onehot_encoder_tree_pipe #(
        .WIDTH          (W),
        .SPLIT          (cfg_s(gi)),
        .IMPLEMENTATION (gj)
      ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .dec_vld (din[W-1:0]),
        .enc_idx (idx_w),
        .enc_vld (vld_w)
`ifdef ONEHOT_ENCODER_ERR_EN
        ,
        .enc_err (err_w)
`endif
      );
      assign obs_idx[gi*NIMP+gj] = 32'(idx_w);
      assign obs_vld[gi*NIMP+gj] = vld_w;
`ifdef ONEHOT_ENCODER_ERR_EN
      assign obs_err[gi*NIMP+gj] = err_w;
`endif
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: index is the OR of all set positions, valid when any bit is
  // set, error when more than one bit is set (counted, not scanned).
  function automatic void ref_enc(input logic [31:0] d, input int w,
                                  output int idx, output bit v, output bit e);
    int cnt;
    idx = 0;
    cnt = 0;
    for (int i = 0; i < w; i++) begin
      if (d[i]) begin
        idx = idx | i;
        cnt = cnt + 1;
      end
    end
    v = (cnt > 0);
    e = (cnt > 1);
  endfunction

  // Apply one input for one edge, then check every DUT's registered result.
  task automatic step(input logic [31:0] d, input logic r);
    int  e_idx;
    bit  e_v;
    bit  e_e;
    int  k;
    din = d;
    rst = r;
    @(posedge clk);
    #1;
    txn++;
    $display("[TB] txn %0d rst=%0b dec_vld=%08h", txn, r, d);
    for (int c = 0; c < NCFG; c++) begin
      ref_enc(d, cfg_w(c), e_idx, e_v, e_e);
      if (r) begin
        e_idx = 0;
        e_v   = 1'b0;
        e_e   = 1'b0;
      end
      for (int m = 0; m < NIMP; m++) begin
        k = c * NIMP + m;
        check($sformatf("idx w%0d imp%0d txn%0d", cfg_w(c), m, txn), obs_idx[k], 32'(e_idx));
        check($sformatf("vld w%0d imp%0d txn%0d", cfg_w(c), m, txn), 32'(obs_vld[k]), 32'(e_v));
`ifdef ONEHOT_ENCODER_ERR_EN
        check($sformatf("err w%0d imp%0d txn%0d", cfg_w(c), m, txn), 32'(obs_err[k]), 32'(e_e));
`endif
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    din = '0;
    rst = 1'b1;
    // Idle: reset two cycles, then zero input
    step(32'h0, 1'b1);
    step(32'h0, 1'b1);
    step(32'h0, 1'b0);
    // Walking one across the widest configuration
    for (int i = 0; i < 32; i++) step(32'h1 << i, 1'b0);
    // Multi-hot: bits 2 and 5 give index 7
    step(32'h0000_0024, 1'b0);
    // Reset mid-stream with the input held
    step(32'h0000_0100, 1'b0);
    step(32'h0000_0100, 1'b1);
    step(32'h0000_0100, 1'b0);
    // Back-to-back with no bubbles
    step(32'h0000_0001, 1'b0);
    step(32'h0000_8000, 1'b0);
    step(32'h0000_0000, 1'b0);
    // Randomized mix of one-hot, zero and multi-hot inputs
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 32'h1 << $urandom_range(0, 31);
        1:       r = 32'h0;
        2:       r = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      step(r, ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
